// File: rtl/quant_pkg.sv
// quant_pkg: shared definitions for the fp32-to-fixed aligner.
//   EXP_MSB/EXP_LSB/MANT_W : fp32 field positions
//   lane_cls_t             : per-lane classification carried from S1 to S2
//   unit_word()            : fixed-point image of 1.mmax for a given OUT_W
package quant_pkg;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MANT_W  = 23;

    typedef enum logic [1:0] {
        ZERO,   // exponent field zero (zero or denormal)
        OVF,    // exponent above the tensor maximum: saturate
        UNF,    // shifted entirely below the output window
        NORM    // regular aligned value
    } lane_cls_t;

    // {2'b01, mmax, (out_w-25) zeros}, returned wide; caller truncates to OUT_W.
    function automatic logic [63:0] unit_word(input logic [MANT_W-1:0] mmax,
                                              input int out_w);
        return 64'({2'b01, mmax}) << (out_w - 25);
    endfunction

endpackage

// File: rtl/quant_align_lane.sv
// quant_align_lane: classification and alignment datapath for one lane.
// Stage S1 captures class, shift distance d and mantissa; stage S2 performs
// the barrel shift and registers the aligned magnitude and flags.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s1_load/s2_load stage advance enables from the top-level handshake
//   act             fp32 activation for this lane
//   emax            tensor-max exponent in force when the beat is accepted
//   mag, ovf, unf   registered aligned magnitude, saturation and underflow flags
//   sign            registered act[31] (only with QUANT_SIGN_EN)
module quant_align_lane
    import quant_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_load,
    input  logic             s2_load,
    input  logic [31:0]      act,
    input  logic [7:0]       emax,
    output logic [OUT_W-1:0] mag,
    output logic             ovf,
    output logic             unf
`ifdef QUANT_SIGN_EN
    ,
    output logic             sign
`endif
);

    localparam int         W   = OUT_W - 24;
    localparam logic [8:0] WIN = 9'(W);

    logic [7:0] exp_in;
    logic [8:0] d_in;
    lane_cls_t  cls_in;

    assign exp_in = act[EXP_MSB:EXP_LSB];
    // Only meaningful when exp_in <= emax, so the 9-bit difference is non-negative.
    assign d_in   = {1'b0, emax} - {1'b0, exp_in};

    always_comb begin
        if (exp_in == 8'd0)
            cls_in = ZERO;
        else if (exp_in > emax)
            cls_in = OVF;
        else if (d_in > WIN)
            cls_in = UNF;
        else
            cls_in = NORM;
    end

    // ---------------- S1 ----------------
    lane_cls_t         s1_cls_reg;
    logic [8:0]        s1_d_reg;
    logic [MANT_W-1:0] s1_mant_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cls_reg  <= ZERO;
            s1_d_reg    <= '0;
            s1_mant_reg <= '0;
        end else if (s1_load) begin
            s1_cls_reg  <= cls_in;
            s1_d_reg    <= d_in;
            s1_mant_reg <= act[MANT_W-1:0];
        end
    end

    // ---------------- S2 ----------------
    logic [OUT_W-1:0] aligned;
    logic [OUT_W-1:0] mag_next;

    // Hidden 1 sits at bit OUT_W-1 before shifting; d <= W keeps it in range.
    assign aligned = {1'b1, s1_mant_reg, {W{1'b0}}} >> s1_d_reg;

    always_comb begin
        mag_next = '0;
        case (s1_cls_reg)
            OVF:     mag_next = '1;
            NORM:    mag_next = aligned;
            default: mag_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (s2_load) begin
            mag <= mag_next;
            ovf <= (s1_cls_reg == OVF);
            unf <= (s1_cls_reg == UNF);
        end
    end

`ifdef QUANT_SIGN_EN
    logic s1_sign_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign_reg <= 1'b0;
            sign        <= 1'b0;
        end else begin
            if (s1_load)
                s1_sign_reg <= act[31];
            if (s2_load)
                sign <= s1_sign_reg;
        end
    end
`else
    // Sign is dropped when the sign output is not built.
    logic unused_sign;
    assign unused_sign = act[31];
`endif

endmodule

// File: rtl/quant_align.sv
// quant_align: pipelined fp32-to-fixed aligner, LANES activations per beat.
// Two stages (S1 classify, S2 shift) with a combinational ready chain.
// Optional feature macro: QUANT_SIGN_EN adds the o_sign output.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_max_we, i_max             load fp32 per-tensor maximum (sign ignored)
//   i_valid, i_ready, i_act     input beat handshake and activations
//   o_valid, o_ready            output beat handshake
//   o_act, o_unit, o_ovf        aligned magnitudes, unit word, saturation flags
//   o_ovf_cnt, o_unf_cnt        saturating lane counters, cleared by i_max_we
//   o_sign                      per-lane sign (QUANT_SIGN_EN only)
module quant_align
    import quant_pkg::*;
#(
    parameter int LANES = 4,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_max_we,
    input  logic [31:0]            i_max,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [32*LANES-1:0]    i_act,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [OUT_W*LANES-1:0] o_act,
    output logic [OUT_W-1:0]       o_unit,
    output logic [LANES-1:0]       o_ovf,
    output logic [CNT_W-1:0]       o_ovf_cnt,
    output logic [CNT_W-1:0]       o_unf_cnt
`ifdef QUANT_SIGN_EN
    ,
    output logic [LANES-1:0]       o_sign
`endif
);

    localparam int POP_W = $clog2(LANES + 1);

    // ---------------- max register ----------------
    logic [7:0]        emax_reg;
    logic [MANT_W-1:0] mmax_reg;
    logic              unused_max_sign;

    assign unused_max_sign = i_max[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            emax_reg <= '0;
            mmax_reg <= '0;
        end else if (i_max_we) begin
            emax_reg <= i_max[EXP_MSB:EXP_LSB];
            mmax_reg <= i_max[MANT_W-1:0];
        end
    end

    // ---------------- handshake / stage valids ----------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_load;
    logic s2_load;

    assign s2_load = ~s2_valid_reg | o_ready;
    assign s1_load = ~s1_valid_reg | s2_load;
    assign i_ready = s1_load & ~rst;
    assign o_valid = s2_valid_reg & ~rst;

    // mmax travels with the beat so o_unit matches the emax used for alignment.
    logic [MANT_W-1:0] s1_mmax_reg;
    logic [OUT_W-1:0]  unit_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            s1_mmax_reg  <= '0;
            unit_reg     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= i_valid;
                s1_mmax_reg  <= mmax_reg;
            end
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                unit_reg     <= OUT_W'(unit_word(s1_mmax_reg, OUT_W));
            end
        end
    end

    assign o_unit = unit_reg;

    // ---------------- lanes ----------------
    logic [LANES-1:0] unf_vec;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            quant_align_lane #(
                .OUT_W (OUT_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .s1_load (s1_load),
                .s2_load (s2_load),
                .act     (i_act[32*gi +: 32]),
                .emax    (emax_reg),
                .mag     (o_act[OUT_W*gi +: OUT_W]),
                .ovf     (o_ovf[gi]),
                .unf     (unf_vec[gi])
`ifdef QUANT_SIGN_EN
                ,
                .sign    (o_sign[gi])
`endif
            );
        end
    endgenerate

    // ---------------- statistics ----------------
    logic [POP_W-1:0] ovf_pop;
    logic [POP_W-1:0] unf_pop;
    logic [CNT_W:0]   ovf_sum;
    logic [CNT_W:0]   unf_sum;
    logic [CNT_W-1:0] ovf_cnt_reg;
    logic [CNT_W-1:0] unf_cnt_reg;

    always_comb begin
        ovf_pop = '0;
        unf_pop = '0;
        for (int k = 0; k < LANES; k++) begin
            ovf_pop = ovf_pop + POP_W'(o_ovf[k]);
            unf_pop = unf_pop + POP_W'(unf_vec[k]);
        end
    end

    assign ovf_sum = {1'b0, ovf_cnt_reg} + (CNT_W+1)'(ovf_pop);
    assign unf_sum = {1'b0, unf_cnt_reg} + (CNT_W+1)'(unf_pop);

    // Clear on a new max takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || i_max_we) begin
            ovf_cnt_reg <= '0;
            unf_cnt_reg <= '0;
        end else if (o_valid && o_ready) begin
            ovf_cnt_reg <= ovf_sum[CNT_W] ? '1 : ovf_sum[CNT_W-1:0];
            unf_cnt_reg <= unf_sum[CNT_W] ? '1 : unf_sum[CNT_W-1:0];
        end
    end

    assign o_ovf_cnt = ovf_cnt_reg;
    assign o_unf_cnt = unf_cnt_reg;

endmodule

// File: tb/tb_quant_align.sv
// tb_quant_align: self-checking bench for quant_align (LANES=4, OUT_W=32).
// Directed table vectors, hand sequences for stall / same-cycle max load /
// mid-stream reset, and a randomized phase checked by a scoreboard model.
module tb_quant_align;

    localparam int LANES = 4;
    localparam int OUT_W = 32;
    localparam int CNT_W = 16;
    localparam int W     = OUT_W - 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_max_we;
    logic [31:0]            i_max;
    logic                   i_valid;
    logic                   i_ready;
    logic [32*LANES-1:0]    i_act;
    logic                   o_valid;
    logic                   o_ready;
    logic [OUT_W*LANES-1:0] o_act;
    logic [OUT_W-1:0]       o_unit;
    logic [LANES-1:0]       o_ovf;
    logic [CNT_W-1:0]       o_ovf_cnt;
    logic [CNT_W-1:0]       o_unf_cnt;
`ifdef QUANT_SIGN_EN
    logic [LANES-1:0]       o_sign;
`endif

    always #5 clk = ~clk;

    quant_align #(.LANES(LANES), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_max_we  (i_max_we),
        .i_max     (i_max),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_act     (i_act),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_act     (o_act),
        .o_unit    (o_unit),
        .o_ovf     (o_ovf),
        .o_ovf_cnt (o_ovf_cnt),
        .o_unf_cnt (o_unf_cnt)
`ifdef QUANT_SIGN_EN
        ,
        .o_sign    (o_sign)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [LANES-1:0][OUT_W-1:0] act;
        logic [OUT_W-1:0]            unit;
        logic [LANES-1:0]            ovf;
        logic [LANES-1:0]            unf;
        logic [LANES-1:0]            sign;
    } beat_t;

    // Value 1.m * 2^(e-emax), expressed with 2^0 at bit OUT_W-1.
    function automatic void ref_lane(input logic [31:0] a, input int emax,
                                     output logic [OUT_W-1:0] mag,
                                     output bit ovf, output bit unf);
        int     e;
        int     d;
        longint sig;
        e   = int'(a[30:23]);
        mag = '0;
        ovf = 0;
        unf = 0;
        if (e == 0) return;
        if (e > emax) begin
            mag = '1;
            ovf = 1;
            return;
        end
        d = emax - e;
        if (d > W) begin
            unf = 1;
            return;
        end
        sig = longint'({1'b1, a[22:0]});
        mag = OUT_W'(sig * (longint'(1) << (W - d)));
    endfunction

    function automatic beat_t make_beat(input logic [LANES-1:0][31:0] acts,
                                        input int emax, input logic [22:0] mmax);
        beat_t b;
        logic [OUT_W-1:0] mag;
        bit ov;
        bit un;
        for (int k = 0; k < LANES; k++) begin
            ref_lane(acts[k], emax, mag, ov, un);
            b.act[k]  = mag;
            b.ovf[k]  = ov;
            b.unf[k]  = un;
            b.sign[k] = acts[k][31];
        end
        b.unit = OUT_W'((longint'(1) << (OUT_W - 2)) + (longint'(mmax) << (OUT_W - 25)));
        return b;
    endfunction

    beat_t       exp_q[$];
    int          m_emax = 0;
    logic [22:0] m_mmax = '0;
    int          m_ovf  = 0;
    int          m_unf  = 0;
    int          n_out  = 0;
    bit          prev_stall = 0;
    logic [OUT_W*LANES-1:0] prev_act;
    logic [OUT_W-1:0]       prev_unit;
    logic [LANES-1:0]       prev_ovf;

    // Scoreboard: observes the handshakes mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            exp_q.delete();
            m_emax     = 0;
            m_mmax     = '0;
            m_ovf      = 0;
            m_unf      = 0;
            prev_stall = 0;
        end else begin
            chk("ovf_cnt", o_ovf_cnt, m_ovf);
            chk("unf_cnt", o_unf_cnt, m_unf);
            if (prev_stall) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_act", o_act, prev_act);
                chk("stall_unit", o_unit, prev_unit);
                chk("stall_ovf", o_ovf, prev_ovf);
            end
            if (o_valid && o_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", o_valid, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("sb_act", o_act, b.act);
                    chk("sb_unit", o_unit, b.unit);
                    chk("sb_ovf", o_ovf, b.ovf);
`ifdef QUANT_SIGN_EN
                    chk("sb_sign", o_sign, b.sign);
`endif
                    m_ovf = m_ovf + $countones(b.ovf);
                    m_unf = m_unf + $countones(b.unf);
                    if (m_ovf > (1 << CNT_W) - 1) m_ovf = (1 << CNT_W) - 1;
                    if (m_unf > (1 << CNT_W) - 1) m_unf = (1 << CNT_W) - 1;
                end
            end
            if (i_max_we) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (i_valid && i_ready)
                exp_q.push_back(make_beat(i_act, m_emax, m_mmax));
            if (i_max_we) begin
                m_emax = int'(i_max[30:23]);
                m_mmax = i_max[22:0];
            end
            prev_stall = o_valid && !o_ready;
            prev_act   = o_act;
            prev_unit  = o_unit;
            prev_ovf   = o_ovf;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_max(input logic [31:0] v);
        i_max_we = 1'b1;
        i_max    = v;
        tick();
        i_max_we = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done    = 0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            tick();
            if (exp_q.size() == 0 && !o_valid) done = 1;
        end
        chk("drain_done", done, 1);
    endtask

    // ---------------- directed table ----------------
    typedef struct packed {
        logic [LANES-1:0][31:0]      act;
        logic [LANES-1:0][OUT_W-1:0] exp_act;
        logic [LANES-1:0]            exp_ovf;
        logic [15:0]                 exp_ovf_cnt;
        logic [15:0]                 exp_unf_cnt;
    } vec_t;

    vec_t tv[4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          n_out0;
        int          cur_e;
        logic [31:0] a;
        int          e;

        // Lane 3 is the leftmost word in each concatenation.
        tv[0].act     = {32'h00000000, 32'h40800000, 32'h3F800000, 32'h40400000};
        tv[0].exp_act = {32'h00000000, 32'h80000000, 32'h20000000, 32'h60000000};
        tv[0].exp_ovf = 4'b0000; tv[0].exp_ovf_cnt = 0; tv[0].exp_unf_cnt = 0;
        tv[1].act     = {32'h00000000, 32'h00000000, 32'h3C000000, 32'h41000000};
        tv[1].exp_act = {32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        tv[1].exp_ovf = 4'b0001; tv[1].exp_ovf_cnt = 1; tv[1].exp_unf_cnt = 1;
        tv[2].act     = {32'h43000000, 32'h00400000, 32'h3FC00000, 32'h3C800000};
        tv[2].exp_act = {32'hFFFFFFFF, 32'h00000000, 32'h30000000, 32'h00800000};
        tv[2].exp_ovf = 4'b1000; tv[2].exp_ovf_cnt = 2; tv[2].exp_unf_cnt = 1;
        tv[3].act     = {32'h7F800000, 32'h3C7FFFFF, 32'h40FFFFFF, 32'h3CFFFFFF};
        tv[3].exp_act = {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF00, 32'h00FFFFFF};
        tv[3].exp_ovf = 4'b1000; tv[3].exp_ovf_cnt = 3; tv[3].exp_unf_cnt = 2;

        rst = 1'b1; i_max_we = 1'b0; i_max = '0; i_valid = 1'b0; i_act = '0; o_ready = 1'b1;
        tick();
        tick();
        chk("rst_o_valid", o_valid, 0);
        chk("rst_i_ready", i_ready, 0);
        chk("rst_o_act", o_act, 0);
        chk("rst_o_unit", o_unit, 0);
        chk("rst_ovf_cnt", o_ovf_cnt, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", i_ready, 1);

        load_max(32'h40800000);
        for (int i = 0; i < 4; i++) begin
            i_act   = tv[i].act;
            i_valid = 1'b1;
            tick();
            i_valid = 1'b0;
            tick();
            chk($sformatf("tv%0d_valid", i), o_valid, 1);
            chk($sformatf("tv%0d_act", i), o_act, tv[i].exp_act);
            chk($sformatf("tv%0d_ovf", i), o_ovf, tv[i].exp_ovf);
            chk($sformatf("tv%0d_unit", i), o_unit, 32'h40000000);
            tick();
            chk($sformatf("tv%0d_ovf_cnt", i), o_ovf_cnt, tv[i].exp_ovf_cnt);
            chk($sformatf("tv%0d_unf_cnt", i), o_unf_cnt, tv[i].exp_unf_cnt);
        end

        // Stream 8 beats, o_ready low for 3 cycles mid-stream.
        n_out0 = n_out;
        sent   = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            o_ready = !(c >= 3 && c < 6);
            i_valid = 1'b1;
            i_act   = {32'h40000000 | 32'(sent << 4), 32'h3C000000,
                       32'h3F800000 | 32'(sent << 10), 32'h41000000};
            #1;
            if (c == 4) chk("stall_i_ready", i_ready, 0);
            if (i_ready) sent++;
            @(posedge clk);
            #1;
        end
        drain();
        chk("stall_beats_out", n_out - n_out0, 8);

        // Max load in the same cycle as a handshake.
        i_act    = {4{32'h3F800000}};
        i_valid  = 1'b1;
        i_max_we = 1'b1;
        i_max    = 32'h3F800000;
        tick();
        i_max_we = 1'b0;
        tick();
        i_valid  = 1'b0;
        chk("we_old_act", o_act, {4{32'h20000000}});
        chk("we_old_unit", o_unit, 32'h40000000);
        chk("we_clr_ovf", o_ovf_cnt, 0);
        chk("we_clr_unf", o_unf_cnt, 0);
        tick();
        chk("we_new_act", o_act, {4{32'h80000000}});
        drain();

        // Mid-stream reset with both stages full.
        i_act   = {4{32'h40000000}};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        drain();
        chk("pre_rst_cnt", o_ovf_cnt, 4);
        o_ready = 1'b0;
        i_valid = 1'b1;
        tick();
        tick();
        chk("full_i_ready", i_ready, 0);
        i_valid = 1'b0;
        rst     = 1'b1;
        tick();
        chk("mid_rst_o_valid", o_valid, 0);
        chk("mid_rst_i_ready", i_ready, 0);
        chk("mid_rst_o_act", o_act, 0);
        chk("mid_rst_o_ovf", o_ovf, 0);
        chk("mid_rst_ovf_cnt", o_ovf_cnt, 0);
        rst     = 1'b0;
        o_ready = 1'b1;
        #1;
        chk("mid_rst_ready_after", i_ready, 1);

        load_max(32'h40800000);
`ifdef QUANT_SIGN_EN
        i_act   = {32'h00000000, 32'h00000000, 32'h00000000, 32'hC0400000};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        chk("sign_bit", o_sign[0], 1);
        chk("sign_mag", o_act[31:0], 32'h60000000);
        drain();
`endif

        // Randomized phase.
        cur_e = 129;
        for (int c = 0; c < 600; c++) begin
            i_valid  = ($urandom % 4) != 0;
            o_ready  = ($urandom % 4) != 0;
            i_max_we = ($urandom % 40) == 0;
            if (i_max_we) begin
                cur_e = 120 + int'($urandom % 16);
                i_max = {1'($urandom), 8'(cur_e), 23'($urandom)};
            end
            for (int k = 0; k < LANES; k++) begin
                if ($urandom % 10 == 0)
                    e = 0;
                else begin
                    e = cur_e - 10 + int'($urandom % 13);
                    if (e < 1) e = 1;
                    if (e > 254) e = 254;
                end
                a = {1'($urandom), 8'(e), 23'($urandom)};
                i_act[32*k +: 32] = a;
            end
            @(posedge clk);
            #1;
        end
        i_max_we = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quant_align.md
# quant_align

Parametrised, pipelined fp32-to-fixed aligner for the CNN quantisation path. It converts LANES fp32 activations per beat into OUT_W-bit unsigned fixed-point magnitudes, aligned to the exponent of a programmed per-tensor maximum. Each beat also carries the matching unit word. It sits between the max-finder and the integer quantiser, and adds valid/ready flow control, a configurable shift window and saturation statistics.

## Interface
- LANES, 4, activations per beat
- OUT_W, 32, output word width; must be ≥ 25; shift window W = OUT_W − 24
- CNT_W, 16, width of the saturation/underflow counters
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- i_max_we  in  1  load i_max into the max register
- i_max  in  32  fp32 per-tensor maximum (sign ignored)
- i_valid  in  1  input beat valid
- i_ready  out  1  input beat accepted when i_valid & i_ready
- i_act  in  32*LANES  fp32 activations; lane k at [32k+31:32k]
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream ready
- o_act  out  OUT_W*LANES  aligned magnitudes
- o_unit  out  OUT_W  unit word for the beat
- o_ovf  out  LANES  per-lane saturation flag
- o_ovf_cnt  out  CNT_W  saturated lanes since last i_max_we
- o_unf_cnt  out  CNT_W  underflowed lanes since last i_max_we
- o_sign  out  LANES  per-lane sign; present only with QUANT_SIGN_EN

## Operation
- Max register (emax, mmax) resets to 0. On i_max_we it loads i_max[30:23] and i_max[22:0].
- A new max applies to beats accepted in the cycle after i_max_we. Beats already in flight keep the emax captured at acceptance; emax is carried down the pipe.
- Per lane, with e = act[30:23], m = act[22:0], d = emax − e (9-bit signed):
  - e == 0 (zero or denormal): output 0, no flag.
  - e > emax: output all-ones, o_ovf = 1.
  - d > W: output 0; counts as underflow.
  - Otherwise: output = {1'b1, m, W zeros} >> d. The leading 1 lands at bit OUT_W−1−d.
- Unit word: o_unit = {2'b01, mmax, (OUT_W−25) zeros}. Before any i_max_we it is 0x40000000 at OUT_W = 32.
- Counters:
  - o_ovf_cnt and o_unf_cnt add the per-beat popcount of lanes flagged, at output handshake.
  - Both saturate at all-ones.
  - Both clear on i_max_we. Clear wins over a same-cycle increment.
- Stage S1 registers the inputs, emax and per-lane class plus d. Stage S2 performs the barrel shift and registers the outputs.

## Timing
- Latency is 2 cycles from input handshake to o_valid with o_ready held high. Throughput is 1 beat/cycle.
- Advance rules:
  - S2 loads when S2 is empty or o_ready.
  - S1 loads when S1 is empty or S2 loads.
  - i_ready = S1 loads (combinational ready chain).
- With o_valid high and o_ready low: o_act, o_unit, o_ovf and o_sign hold stable, and no beat is lost or duplicated.
- Reset (any cycle, including mid-stream) flushes both stages.
  - During rst: o_valid = 0, i_ready = 0, o_act/o_unit/o_ovf/o_sign = 0, counters = 0, max register = 0.
  - i_ready = 1 on the first cycle after rst deasserts.
- i_max_we and an input handshake in the same cycle: the beat uses the old emax.

## Configuration
- QUANT_SIGN_EN defined: the o_sign port exists and carries act[31] per lane, piped alongside o_act.
- QUANT_SIGN_EN undefined: no o_sign port, and sign bits are discarded. Magnitude behaviour is identical in both cases.

## Structure
- Package quant_pkg holds:
  - fp32 field constants: EXP_MSB = 30, EXP_LSB = 23, MANT_W = 23.
  - The lane-class enum: ZERO, OVF, UNF, NORM.
  - The function computing the unit word from mmax and OUT_W.
- One sub-module, quant_align_lane. It covers the classification and shift datapath for one lane and is instantiated LANES times. Handshake, max register and counters stay in the top.

## Test plan
- Set i_max = 0x40800000 (emax 129), OUT_W = 32. Send lanes 0x40400000, 0x3F800000, 0x40800000, 0x00000000.
  - Expect o_act 0x60000000, 0x20000000, 0x80000000, 0x00000000 two cycles later.
  - Expect o_unit 0x40000000.
- Same max, lanes 0x41000000 and 0x3C000000 (e = 120, d = 9).
  - Expect 0xFFFFFFFF with o_ovf = 1 for the first lane, and 0 for the second.
  - Expect o_ovf_cnt = 1 and o_unf_cnt = 1.
- Stream 8 beats while holding o_ready low for 3 cycles mid-stream. Expect all 8 beats out in order, with outputs stable while stalled and i_ready low once both stages are full.
- Issue i_max_we with 0x3F800000 in the same cycle as a beat handshake. Expect that beat aligned to emax 129, the next beat to emax 127, and both counters cleared.
- Assert rst for one cycle with both stages full. Expect o_valid = 0 and counters = 0 during rst, and i_ready = 1 the following cycle.
- With QUANT_SIGN_EN, input 0xC0400000. Expect o_sign = 1 and o_act = 0x60000000 under max 0x40800000.
